// File: rtl/maxnet_controller.sv
// ---------------------------------------------------------------------------
// maxnet_controller
//
// Sequencer for an N-neuron Maxnet (winner-take-all) datapath. A run:
//   1. LOAD      : stream N activations out of the input memory into the
//                  neuron registers (1-cycle memory read latency, so each
//                  ld_sel trails mem_addr by one cycle).
//   2. LOAD_WAIT : capture the last memory word.
//   3. CHECK     : inspect the per-neuron nonzero flags. A single survivor
//                  ends the run with a winner. No survivors means every
//                  neuron annihilated (a tie) and the run ends without one.
//                  Several survivors start another CALC/UPD iteration.
//
// Optional feature (macro MAXNET_ITER_LIMIT_EN):
//   defined   - a run with several survivors after MAX_ITER iterations
//               stops with timeout=1, valid_win=0, winner=0.
//   undefined - no cap; timeout is tied to 0 and iter_cnt wraps mod 32.
//
// Parameters:
//   N        number of neurons, 2..8
//   MAX_ITER iteration cap, 1..31 (only acted on with the macro defined)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (forces IDLE, outputs 0)
//   start      level request; a run launches on its rising edge
//   nz         per-neuron "activation nonzero" flags from the datapath
//   mem_rd     input memory read strobe
//   mem_addr   input memory word address
//   ld_en      load memory read data into neuron register ld_sel
//   ld_sel     neuron register being loaded
//   calc_en    datapath computes the lateral-inhibition update
//   upd_en     datapath writes the computed values back
//   busy       run in progress (LOAD..CHECK)
//   done       result held (DONE state)
//   winner     index of the surviving neuron
//   valid_win  exactly one neuron survived
//   iter_cnt   number of completed iterations
//   timeout    iteration cap reached
// ---------------------------------------------------------------------------
module maxnet_controller #(
  parameter int N        = 4,
  parameter int MAX_ITER = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0]         nz,
  output logic                 mem_rd,
  output logic [$clog2(N)-1:0] mem_addr,
  output logic                 ld_en,
  output logic [$clog2(N)-1:0] ld_sel,
  output logic                 calc_en,
  output logic                 upd_en,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] winner,
  output logic                 valid_win,
  output logic [4:0]           iter_cnt,
  output logic                 timeout
);

  localparam int AW = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("maxnet_controller: N must be in 2..8");
  end
  if (MAX_ITER < 1 || MAX_ITER > 31) begin : g_bad_max_iter
    $error("maxnet_controller: MAX_ITER must be in 1..31");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_WAIT,
    S_CALC,
    S_UPD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic            start_d;
  logic            launch;
  logic [AW-1:0]   k, k_nxt;
  logic [4:0]      iter_nxt;
  logic [AW-1:0]   winner_nxt;
  logic            valid_nxt;
  logic [3:0]      nz_count;

  // Number of neurons still alive.
  function automatic logic [3:0] popcount(input logic [N-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + 4'(v[i]);
    end
    return cnt;
  endfunction

  // Index of the lowest set flag; only used when exactly one flag is set.
  function automatic logic [AW-1:0] lowest_index(input logic [N-1:0] v);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = AW'(i);
      end
    end
    return idx;
  endfunction

  assign launch   = start & ~start_d;
  assign nz_count = popcount(nz);
  assign busy     = (state == S_LOAD) || (state == S_LOAD_WAIT) ||
                    (state == S_CALC) || (state == S_UPD) || (state == S_CHECK);
  assign done     = (state == S_DONE);

`ifdef MAXNET_ITER_LIMIT_EN
  logic timeout_r, timeout_nxt;
  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      start_d   <= 1'b0;
      k         <= '0;
      iter_cnt  <= '0;
      winner    <= '0;
      valid_win <= 1'b0;
`ifdef MAXNET_ITER_LIMIT_EN
      timeout_r <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      start_d   <= start;
      k         <= k_nxt;
      iter_cnt  <= iter_nxt;
      winner    <= winner_nxt;
      valid_win <= valid_nxt;
`ifdef MAXNET_ITER_LIMIT_EN
      timeout_r <= timeout_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    iter_nxt   = iter_cnt;
    winner_nxt = winner;
    valid_nxt  = valid_win;
`ifdef MAXNET_ITER_LIMIT_EN
    timeout_nxt = timeout_r;
`endif
    mem_rd   = 1'b0;
    mem_addr = '0;
    ld_en    = 1'b0;
    ld_sel   = '0;
    calc_en  = 1'b0;
    upd_en   = 1'b0;

    unique case (state)
      S_IDLE, S_DONE: begin
        // A rising start edge anywhere else is deliberately dropped.
        if (launch) begin
          state_nxt  = S_LOAD;
          k_nxt      = '0;
          iter_nxt   = '0;
          winner_nxt = '0;
          valid_nxt  = 1'b0;
`ifdef MAXNET_ITER_LIMIT_EN
          timeout_nxt = 1'b0;
`endif
        end
      end

      S_LOAD: begin
        mem_rd   = 1'b1;
        mem_addr = k;
        // Read data for address k-1 arrives now.
        if (k != '0) begin
          ld_en  = 1'b1;
          ld_sel = k - AW'(1);
        end
        if (k == AW'(N - 1)) begin
          state_nxt = S_LOAD_WAIT;
          k_nxt     = '0;
        end else begin
          k_nxt = k + AW'(1);
        end
      end

      S_LOAD_WAIT: begin
        ld_en     = 1'b1;
        ld_sel    = AW'(N - 1);
        state_nxt = S_CHECK;
      end

      S_CALC: begin
        calc_en   = 1'b1;
        state_nxt = S_UPD;
      end

      S_UPD: begin
        upd_en    = 1'b1;
        iter_nxt  = iter_cnt + 5'd1;
        state_nxt = S_CHECK;
      end

      S_CHECK: begin
        if (nz_count == 4'd1) begin
          state_nxt  = S_DONE;
          valid_nxt  = 1'b1;
          winner_nxt = lowest_index(nz);
        end else if (nz_count == 4'd0) begin
          state_nxt  = S_DONE;
          valid_nxt  = 1'b0;
          winner_nxt = '0;
`ifdef MAXNET_ITER_LIMIT_EN
        end else if (iter_cnt == 5'(MAX_ITER)) begin
          state_nxt   = S_DONE;
          timeout_nxt = 1'b1;
          valid_nxt   = 1'b0;
          winner_nxt  = '0;
`endif
        end else begin
          state_nxt = S_CALC;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// ---------------------------------------------------------------------------
// tb_maxnet_controller
//
// Bench for maxnet_controller (N=4, MAX_ITER=5). The datapath is modelled as
// a list of nz values: entry j is what the neuron flags read after j
// iterations. Expected results are derived by walking that list with the
// winner-take-all termination rules and queued; a monitor compares them
// against the DUT whenever done rises. Honours MAXNET_ITER_LIMIT_EN.
// ---------------------------------------------------------------------------
module tb_maxnet_controller;

  localparam int N        = 4;
  localparam int AW       = $clog2(N);
  localparam int MAX_ITER = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  nz;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          ld_en;
  logic [AW-1:0] ld_sel;
  logic          calc_en;
  logic          upd_en;
  logic          busy;
  logic          done;
  logic [AW-1:0] winner;
  logic          valid_win;
  logic [4:0]    iter_cnt;
  logic          timeout;

  maxnet_controller #(.N(N), .MAX_ITER(MAX_ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nz        (nz),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .calc_en   (calc_en),
    .upd_en    (upd_en),
    .busy      (busy),
    .done      (done),
    .winner    (winner),
    .valid_win (valid_win),
    .iter_cnt  (iter_cnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: the flag pattern advances on every write-back.
  logic [N-1:0] seq [0:63];
  int           seq_len = 1;
  int           nz_idx  = 0;
  always @(posedge clk) begin
    if (ld_en)       nz_idx <= 0;
    else if (upd_en) nz_idx <= nz_idx + 1;
  end
  assign nz = seq[(nz_idx < seq_len) ? nz_idx : seq_len - 1];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  typedef struct {
    int unsigned   done_cyc;
    logic          vw;
    logic [AW-1:0] win;
    logic [4:0]    iters;
    logic          to;
  } exp_t;

  exp_t sb[$];

  // Reference model: walk the flag list with the termination rules.
  task automatic push_expect(input int unsigned launch_cyc);
    exp_t         e;
    int           j;
    logic [N-1:0] v;
    bit           fin;
    e.vw = 1'b0; e.win = '0; e.to = 1'b0;
    j = 0; fin = 0;
    while (!fin && j < 64) begin
      v = seq[(j < seq_len) ? j : seq_len - 1];
      if ($countones(v) == 1) begin
        e.vw = 1'b1;
        for (int b = 0; b < N; b++) if (v[b]) e.win = AW'(b);
        fin = 1;
      end else if ($countones(v) == 0) begin
        fin = 1;
`ifdef MAXNET_ITER_LIMIT_EN
      end else if (j == MAX_ITER) begin
        e.to = 1'b1;
        fin  = 1;
`endif
      end else begin
        j++;
      end
    end
    e.iters    = 5'(j);
    e.done_cyc = launch_cyc + N + 2 + 3 * j;
    sb.push_back(e);
  endtask

  // Monitor
  logic done_q     = 1'b0;
  logic strobe_bad = 1'b0;
  logic bad_now;
  bit   mon_ok;
  exp_t mon_e;
  int   ld_log[$];
  int   addr_log[$];

  always @(negedge clk) begin
    bad_now = ((int'(ld_en) + int'(calc_en) + int'(upd_en)) > 1) ||
              (!busy && (ld_en || calc_en || upd_en || mem_rd));
    if (bad_now) strobe_bad <= 1'b1;
    if (ld_en)  ld_log.push_back(int'(ld_sel));
    if (mem_rd) addr_log.push_back(int'(mem_addr));
    if (!rst) begin
      ld_log.delete();
      addr_log.delete();
      strobe_bad <= 1'b0;
    end else if (done && !done_q) begin
      chk("done_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
        chk("valid_win", 64'(valid_win), 64'(mon_e.vw));
        chk("winner", 64'(winner), 64'(mon_e.win));
        chk("iter_cnt", 64'(iter_cnt), 64'(mon_e.iters));
        chk("timeout", 64'(timeout), 64'(mon_e.to));
        mon_ok = (ld_log.size() == N) && (addr_log.size() == N);
        if (mon_ok) begin
          for (int i = 0; i < N; i++) if (ld_log[i] != i || addr_log[i] != i) mon_ok = 0;
        end
        chk("load_sequence", 64'(mon_ok), 64'd1);
        chk("strobe_rules", 64'(strobe_bad | bad_now), 64'd0);
      end
      ld_log.delete();
      addr_log.delete();
      strobe_bad <= 1'b0;
    end
    done_q <= done;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_within_budget", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic run_seq();
    start = 1'b1;
    push_expect(cyc + 1);
    tick();
    start = 1'b0;
    wait_done(300);
    tick(2);
  endtask

  function automatic logic [18:0] all_outputs();
    return {mem_rd, mem_addr, ld_en, ld_sel, calc_en, upd_en, busy, done,
            winner, valid_win, iter_cnt, timeout};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    seq[0] = 4'b0100; seq_len = 1;

    // Reset with start held high; launch on the first edge after release.
    rst = 1'b0; start = 1'b1;
    tick(3);
    chk("reset_outputs", 64'(all_outputs()), 64'd0);
    rst = 1'b1;
    push_expect(cyc + 1);
    wait_done(100);
    start = 1'b0;
    tick(2);

    // Two iterations, winner 1.
    seq[0] = 4'b1111; seq[1] = 4'b1011; seq[2] = 4'b0010; seq_len = 3;
    run_seq();

    // Annihilation tie after one iteration.
    seq[0] = 4'b1001; seq[1] = 4'b0000; seq_len = 2;
    run_seq();

    // Long start level plus a second pulse while busy: one run only.
    seq[0] = 4'b1111; seq[1] = 4'b1111; seq[2] = 4'b0111; seq[3] = 4'b0001; seq_len = 4;
    start = 1'b1;
    push_expect(cyc + 1);
    tick(10);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100);
    tick(3);
    chk("hold_in_done", 64'({done, busy, winner, valid_win, iter_cnt}),
        64'({1'b1, 1'b0, 2'd0, 1'b1, 5'd3}));

    // Relaunch from DONE clears the previous result.
    seq[0] = 4'b0100; seq_len = 1;
    start = 1'b1;
    push_expect(cyc + 1);
    tick();
    start = 1'b0;
    chk("cleared_on_relaunch", 64'({done, busy, valid_win, winner, iter_cnt, timeout}),
        64'({1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0}));
    wait_done(100);
    tick(2);

    // Asynchronous reset in the CALC of the third iteration.
    for (int i = 0; i < 5; i++) seq[i] = 4'b1111;
    seq[5] = 4'b0100; seq_len = 6;
    start = 1'b1;
    push_expect(cyc + 1);
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (calc_en && iter_cnt == 5'd2) found = 1;
      else tick();
    end
    chk("reached_third_calc", 64'(found), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(all_outputs()), 64'd0);
    sb.delete();
    tick(2);
    rst = 1'b1;
    tick();
    seq[0] = 4'b1100; seq[1] = 4'b0100; seq_len = 2;
    run_seq();

    // Randomized flag histories.
    for (int r = 0; r < 10; r++) begin
      int           len;
      int           t;
      logic [N-1:0] v;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len - 1; i++) begin
        do v = N'($urandom); while ($countones(v) < 2);
        seq[i] = v;
      end
      t = $urandom_range(0, N);
      seq[len - 1] = (t == N) ? '0 : N'(1 << t);
      seq_len = len;
      run_seq();
    end

    // Flags that never converge.
    seq[0] = 4'b0011; seq_len = 1;
`ifdef MAXNET_ITER_LIMIT_EN
    run_seq();
`else
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(200);
    chk("no_done_uncapped", 64'({done, busy}), 64'({1'b0, 1'b1}));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
